// File: rtl/bit_serializer_if.sv
// Load-side handshake between an upstream word source and bit_serializer.
//   load_valid : source has a word on load_data
//   load_data  : WIDTH-bit word to serialize
//   load_ready : serializer can take a word this cycle
// master = upstream source, slave = serializer.
interface bit_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, one bit per clk out,
// feeding the serial input of the downstream sequence detector. A one-word
// holding register lets the source preload the next word so back-to-back
// words come out as a gapless stream.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-low reset
//   ld         : load handshake (slave side of bit_serializer_if)
//   ser_out    : current serial bit
//   ser_valid  : ser_out carries a real data bit
//   frame_done : high while the last bit of a word is on ser_out
//
// state | meaning
// IDLE  | nothing shifting, SR is zero, waiting for a word
// SHIFT | SR bit at the output end is on ser_out, CNT counts bits of the word
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    bit_serializer_if.slave    ld,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               frame_done
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] hr_q, hr_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_shifted;
    logic             xfer;
    logic             last_bit;

    assign ld.load_ready = ~hold_full_q;
    assign xfer          = ld.load_valid & ~hold_full_q;
    assign last_bit      = (cnt_q == LAST);

    assign sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sr_q[WIDTH-1:1]};

    // SR is forced to zero whenever the FSM sits in IDLE, so the output bit
    // can come straight off the register without gating by state.
    assign ser_out    = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
    assign ser_valid  = (state_q == SHIFT);
    assign frame_done = (state_q == SHIFT) && last_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            hr_q        <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            hr_q        <= hr_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        hr_d        = hr_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    sr_d    = ld.load_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    // Word boundary: reload from HR first, else take a word
                    // offered on this very edge, else drain to IDLE.
                    cnt_d = '0;
                    if (hold_full_q) begin
                        sr_d        = hr_q;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        sr_d = ld.load_data;
                    end else begin
                        sr_d    = '0;
                        state_d = IDLE;
                    end
                end else begin
                    sr_d  = sr_shifted;
                    cnt_d = cnt_q + CW'(1);
                    if (xfer) begin
                        hr_d        = ld.load_data;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
